alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_iter.sv | 61 ++++++
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_PASS = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_UDIV = 4'b1001,
        OP_UREM = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Bit-serial engine: shift-add multiply or restoring divide, one bit per step.
module alu_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         load,
    input  logic         step,
    input  logic         div,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi
);

    // acc: product accumulator or partial remainder
    // sh:  left-shifting multiplicand, or dividend bits out / quotient bits in
    // opd: right-shifting multiplier, or the fixed divisor
    logic [N-1:0] acc, sh, opd;
    logic         div_mode;
    logic [N-1:0] acc_nxt, sh_nxt, opd_nxt;
    logic [N:0]   rsh, trial;

    always_comb begin
        acc_nxt = acc;
        sh_nxt  = sh;
        opd_nxt = opd;
        rsh     = {acc, sh[N-1]};
        trial   = rsh - {1'b0, opd};
        if (div_mode) begin
            // Partial remainder is always below the divisor, so rsh fits N+1 bits
            if (!trial[N]) begin
                acc_nxt = trial[N-1:0];
                sh_nxt  = {sh[N-2:0], 1'b1};
            end else begin
                acc_nxt = rsh[N-1:0];
                sh_nxt  = {sh[N-2:0], 1'b0};
            end
        end else begin
            acc_nxt = opd[0] ? (acc + sh) : acc;
            sh_nxt  = sh << 1;
            opd_nxt = opd >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= '0;
            sh       <= a;
            opd      <= b;
            div_mode <= div;
        end else if (step) begin
            acc <= acc_nxt;
            sh  <= sh_nxt;
            opd <= opd_nxt;
        end
    end

    assign lo = div_mode ? sh : acc;
    assign hi = acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub, iterative mul/div/rem, registered flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         busy,
    output logic         done,
    output logic         exc_divzero,
    output logic         exc_invop
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state;
    logic           vld_p0;
    logic [N-1:0]   a_p0, b_p0;
    logic [3:0]     op_p0;
    logic [CW-1:0]  cnt;

    logic           accept, step;
    logic [N-1:0]   it_lo, it_hi;
    logic [N:0]     sum_p0, dif_p0;
    logic signed [N-1:0] a_s, b_s;
    logic [N-1:0]   res_c, fin_res;
    logic           c_c, v_c, dz_c, io_c, exc_c;

    function automatic logic add_ovf(input logic signed [N-1:0] x, y, r);
        return (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [N-1:0] x, y, r);
        return (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
    endfunction

    // A second start is not taken while the latched op is still being decoded
    assign accept = start && (state == S_IDLE) && !vld_p0;
    assign step   = (state == S_IDLE && vld_p0 && is_iter_op(op_p0) && b_p0 != '0)
                 || (state == S_ITER && cnt != LAST);

    alu_iter #(.N(N)) u_iter (
        .clk  (clk),
        .load (accept),
        .step (step),
        .div  (ALUControl != OP_MUL),
        .a    (a),
        .b    (b),
        .lo   (it_lo),
        .hi   (it_hi)
    );

    // Stage p0: operand capture
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= a;
            b_p0  <= b;
            op_p0 <= ALUControl;
        end
    end

    assign a_s = a_p0;
    assign b_s = b_p0;

    always_comb begin
        sum_p0 = {1'b0, a_p0} + {1'b0, b_p0};
        dif_p0 = {1'b0, a_p0} + {1'b0, ~b_p0} + {{N{1'b0}}, 1'b1};
        res_c  = '0;
        c_c    = 1'b0;
        v_c    = 1'b0;
        dz_c   = 1'b0;
        io_c   = 1'b0;
        case (op_p0)
            OP_AND:  res_c = a_p0 & b_p0;
            OP_OR:   res_c = a_p0 | b_p0;
            OP_ADD: begin
                res_c = sum_p0[N-1:0];
                c_c   = sum_p0[N];
                v_c   = add_ovf(a_s, b_s, sum_p0[N-1:0]);
            end
            OP_SUB: begin
                res_c = dif_p0[N-1:0];
                c_c   = dif_p0[N];
                v_c   = sub_ovf(a_s, b_s, dif_p0[N-1:0]);
            end
            OP_PASS: res_c = b_p0;
            OP_MUL:  res_c = '0;
            OP_UDIV: if (b_p0 == '0) begin
                res_c = '1;
                dz_c  = 1'b1;
            end
            OP_UREM: if (b_p0 == '0) begin
                res_c = a_p0;
                dz_c  = 1'b1;
            end
            default: io_c = 1'b1;
        endcase
        exc_c   = dz_c || io_c;
        fin_res = (state == S_ITER) ? ((op_p0 == OP_UREM) ? it_hi : it_lo) : res_c;
    end

    // Stage p1: FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            vld_p0      <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            negative    <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            exc_divzero <= 1'b0;
            exc_invop   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (vld_p0) begin
                        vld_p0 <= 1'b0;
                        if (is_iter_op(op_p0) && b_p0 != '0) begin
                            state <= S_ITER;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result      <= fin_res;
                            zero        <= !exc_c && (fin_res == '0);
                            negative    <= !exc_c && fin_res[N-1];
                            carry       <= c_c;
                            overflow    <= v_c;
                            exc_divzero <= dz_c;
                            exc_invop   <= io_c;
                        end
                    end else if (accept) begin
                        vld_p0      <= 1'b1;
                        exc_divzero <= 1'b0;
                        exc_invop   <= 1'b0;
                    end
                end
                S_ITER: begin
                    if (cnt == LAST) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= fin_res;
                        zero     <= (fin_res == '0);
                        negative <= fin_res[N-1];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (N=64): directed cases plus random ops against an arithmetic reference.
module tb_alu_seq;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] a, b;
    logic [3:0]   ALUControl;
    logic [N-1:0] result;
    logic         zero, negative, carry, overflow, busy, done, exc_divzero, exc_invop;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] res;
        logic        z, n, c, v, dz, io;
        int          lat;
    } exp_t;

    alu_seq #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .ALUControl  (ALUControl),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done),
        .exc_divzero (exc_divzero),
        .exc_invop   (exc_invop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        logic [64:0] u;
        logic signed [64:0] sx;
        e.res = '0; e.z = 0; e.n = 0; e.c = 0; e.v = 0; e.dz = 0; e.io = 0; e.lat = 1;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: begin
                u = {1'b0, x} + {1'b0, y};
                e.res = u[63:0];
                e.c = u[64];
                sx = $signed({x[63], x}) + $signed({y[63], y});
                e.v = sx[64] ^ sx[63];
            end
            4'b0110: begin
                e.res = x - y;
                e.c = (x >= y);
                sx = $signed({x[63], x}) - $signed({y[63], y});
                e.v = sx[64] ^ sx[63];
            end
            4'b0111: e.res = y;
            4'b1000: begin e.res = x * y; e.lat = N + 1; end
            4'b1001: if (y == 0) begin e.res = '1; e.dz = 1; end
                     else begin e.res = x / y; e.lat = N + 1; end
            4'b1010: if (y == 0) begin e.res = x; e.dz = 1; end
                     else begin e.res = x % y; e.lat = N + 1; end
            default: e.io = 1;
        endcase
        if (!e.dz && !e.io) begin
            e.z = (e.res == 0);
            e.n = e.res[63];
        end
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    task automatic run_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y, input bit poke);
        exp_t e;
        int lat, bcnt;
        e = model(op, x, y);
        start = 1; ALUControl = op; a = x; b = y;
        @(posedge clk); #1;
        start = 0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; ALUControl = 4'($urandom);
        lat = 0; bcnt = 0;
        do begin
            start = poke && (lat == 3);
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end while (done !== 1'b1 && lat < 200);
        check("latency", 64'(lat), 64'(e.lat));
        check("busy_cycles", 64'(bcnt), (e.lat > 1) ? 64'(N) : 64'd0);
        check("result", result, e.res);
        check("flags_zncv", {60'd0, zero, negative, carry, overflow}, {60'd0, e.z, e.n, e.c, e.v});
        check("exceptions", {62'd0, exc_divzero, exc_invop}, {62'd0, e.dz, e.io});
        start = poke; ALUControl = 4'b0111; b = ~e.res;
        @(posedge clk); #1;
        start = 0;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        check("start_in_done_ignored", {63'd0, done}, 64'd0);
        check("result_held", result, e.res);
    endtask

    initial begin
        logic [3:0] ops [10];
        logic [3:0] op;
        logic [63:0] x, y;
        int seen;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111, 4'b0011};

        reset = 1; start = 0; a = '0; b = '0; ALUControl = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_ctrl", {57'd0, zero, negative, carry, overflow, busy, done, exc_divzero},
              64'd0);
        check("reset_invop", {63'd0, exc_invop}, 64'd0);
        reset = 0;
        @(posedge clk); #1;

        run_op(4'b0010, 64'hffff_ffff_ffff_ffff, 64'd2, 0);
        check("add_const", result, 64'd1);
        run_op(4'b0110, 64'd0, 64'd1, 0);
        run_op(4'b0110, 64'd2, 64'd2, 0);
        run_op(4'b0010, 64'h7fff_ffff_ffff_ffff, 64'd1, 0);
        run_op(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 1);
        run_op(4'b1000, 64'd150, 64'd27, 1);
        check("mul_const", result, 64'd4050);
        run_op(4'b1001, 64'd100, 64'd7, 1);
        check("udiv_const", result, 64'd14);
        run_op(4'b1010, 64'd100, 64'd7, 1);
        check("urem_const", result, 64'd2);
        run_op(4'b1001, 64'd5, 64'd0, 1);
        run_op(4'b1010, 64'd0, 64'd0, 0);
        run_op(4'b1111, 64'd9, 64'd3, 0);
        run_op(4'b0111, 64'd1, 64'h8000_0000_0000_0000, 0);
        run_op(4'b1001, 64'hffff_ffff_ffff_ffff, 64'h8000_0000_0000_0001, 0);

        // Abort a multiply part-way through
        start = 1; ALUControl = 4'b1000; a = 64'd123456; b = 64'd789;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_flags", {58'd0, zero, negative, carry, overflow, exc_divzero, exc_invop}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Reset wins over a simultaneous start
        reset = 1; start = 1; ALUControl = 4'b0010; a = 64'd5; b = 64'd6;
        @(posedge clk); #1;
        reset = 0; start = 0;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("reset_start_dropped", 64'(seen), 64'd0);
        check("reset_start_result", result, 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) y = 64'($urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 7) == 0) x = y;
            run_op(op, x, y, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
